// File: rtl/soc_periph_arbiter.sv
// soc_periph_arbiter
// Two-master round-robin arbiter in front of a single shared peripheral port.
// The winner's address is decoded against the SoC memory map. Misses never
// reach the peripheral: the master receives a local grant followed by an error
// response. Only one transaction is outstanding at a time.
// Optional feature: define SOC_PERIPH_ARB_TIMEOUT_EN to add an 8-bit watchdog.
// The watchdog aborts a stalled request phase or response phase.
module soc_periph_arbiter #(
    parameter int unsigned NrMasters = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NrMasters-1:0]                     m_req_i,
    input  logic [NrMasters-1:0]                     m_we_i,
    input  logic [NrMasters-1:0][AddrWidth-1:0]      m_addr_i,
    input  logic [NrMasters-1:0][DataWidth-1:0]      m_wdata_i,
    input  logic [NrMasters-1:0][DataWidth/8-1:0]    m_be_i,
    output logic [NrMasters-1:0]                     m_gnt_o,
    output logic [NrMasters-1:0]                     m_rvalid_o,
    output logic [NrMasters-1:0]                     m_err_o,
    output logic [DataWidth-1:0]                     m_rdata_o,
    output logic                                     s_req_o,
    output logic                                     s_we_o,
    output logic [AddrWidth-1:0]                     s_addr_o,
    output logic [DataWidth-1:0]                     s_wdata_o,
    output logic [DataWidth/8-1:0]                   s_be_o,
    output logic [10:0]                              s_sel_o,
    input  logic                                     s_gnt_i,
    input  logic                                     s_rvalid_i,
    input  logic                                     s_err_i,
    input  logic [DataWidth-1:0]                     s_rdata_i
);

    localparam int unsigned NrRegions = 11;

    // Region table. The index is the select bit:
    // CLIC=0, DRAM=1, GPIO=2, Ethernet=3, SPI=4, Timer=5, UART=6,
    // PLIC=7, CLINT=8, ROM=9, Debug=10.
    localparam logic [NrRegions-1:0][63:0] RegionBase = {
        64'h0000_0000,      // Debug
        64'h0001_0000,      // ROM
        64'h0200_0000,      // CLINT
        64'h0C00_0000,      // PLIC
        64'h1000_0000,      // UART
        64'h1800_0000,      // Timer
        64'h2000_0000,      // SPI
        64'h3000_0000,      // Ethernet
        64'h4000_0000,      // GPIO
        64'h8000_0000,      // DRAM
        64'h5000_0000       // CLIC
    };
    localparam logic [NrRegions-1:0][63:0] RegionLen = {
        64'h0000_1000,      // Debug
        64'h0001_0000,      // ROM
        64'h000C_0000,      // CLINT
        64'h03FF_FFFF,      // PLIC
        64'h0000_1000,      // UART
        64'h0000_1000,      // Timer
        64'h0080_0000,      // SPI
        64'h0001_0000,      // Ethernet
        64'h0000_1000,      // GPIO
        64'h4000_0000,      // DRAM
        64'h03FF_FFFF       // CLIC
    };

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DEC_GNT,
        DEC_RSP
    } state_t;

    state_t                 state_reg;
    logic                   prio_reg;      // master that wins a tie
    logic                   win_reg;       // master owning the current transaction
    logic [AddrWidth-1:0]   addr_reg;
    logic                   we_reg;
    logic [DataWidth-1:0]   wdata_reg;
    logic [DataWidth/8-1:0] be_reg;
    logic [NrRegions-1:0]   sel_reg;

    logic                   win_next;
    logic [63:0]            cand_addr;
    logic [NrRegions-1:0]   dec_sel;
    logic                   timeout;
    logic                   gnt_fire;
    logic                   rsp_fire;
    logic                   rsp_any;
    logic                   err_any;

    // On a tie, the master not served last wins. A lone requester always wins.
    assign win_next  = (m_req_i[0] & m_req_i[1]) ? prio_reg : m_req_i[1];
    assign cand_addr = 64'(m_addr_i[win_next]);

    // The unsigned offset wraps to a huge value below Base.
    // Therefore a single compare covers Base <= addr < Base+Length.
    generate
        for (genvar gi = 0; gi < NrRegions; gi++) begin : g_decode
            assign dec_sel[gi] = (cand_addr - RegionBase[gi]) < RegionLen[gi];
        end
    endgenerate

`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_reg;

    assign timeout = (state_reg == REQ || state_reg == WAIT_RSP) && (to_cnt_reg == 8'hFF);

    // Watchdog: restarts when a hit enters REQ.
    // It keeps counting through REQ and WAIT_RSP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_reg <= 8'd0;
        end else if (state_reg == IDLE) begin
            to_cnt_reg <= 8'd0;
        end else if ((state_reg == REQ || state_reg == WAIT_RSP) && !timeout) begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Transaction FSM: arbitrate, latch, handshake with the peripheral or
    // emit a local decode error, then hand priority to the other master.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            win_reg   <= 1'b0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            be_reg    <= '0;
            sel_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|m_req_i) begin
                        win_reg   <= win_next;
                        addr_reg  <= m_addr_i[win_next];
                        we_reg    <= m_we_i[win_next];
                        wdata_reg <= m_wdata_i[win_next];
                        be_reg    <= m_be_i[win_next];
                        sel_reg   <= dec_sel;
                        state_reg <= (|dec_sel) ? REQ : DEC_GNT;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        state_reg <= DEC_GNT;
                    end else if (s_gnt_i) begin
                        state_reg <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (timeout) begin
                        state_reg <= DEC_RSP;
                    end else if (s_rvalid_i) begin
                        prio_reg  <= ~win_reg;
                        state_reg <= IDLE;
                    end
                end
                DEC_GNT: begin
                    state_reg <= DEC_RSP;
                end
                DEC_RSP: begin
                    prio_reg  <= ~win_reg;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Peripheral side: the request is live only in REQ.
    // The select line is quiet otherwise.
    assign s_req_o   = (state_reg == REQ) && !timeout;
    assign s_sel_o   = s_req_o ? sel_reg : '0;
    assign s_addr_o  = addr_reg;
    assign s_we_o    = we_reg;
    assign s_wdata_o = wdata_reg;
    assign s_be_o    = be_reg;

    // Master side events. Grant and response follow the peripheral in the
    // same cycle. Decode errors come from the DEC_* states.
    assign gnt_fire  = (s_req_o && s_gnt_i) || (state_reg == DEC_GNT);
    assign rsp_fire  = (state_reg == WAIT_RSP) && s_rvalid_i && !timeout;
    assign rsp_any   = rsp_fire || (state_reg == DEC_RSP);
    assign err_any   = (rsp_fire && s_err_i) || (state_reg == DEC_RSP);
    assign m_rdata_o = rsp_fire ? s_rdata_i : '0;

    // Route events to the winner only; the other master sees zeros.
    generate
        for (genvar gi = 0; gi < NrMasters; gi++) begin : g_master
            assign m_gnt_o[gi]    = gnt_fire && (win_reg == 1'(gi));
            assign m_rvalid_o[gi] = rsp_any  && (win_reg == 1'(gi));
            assign m_err_o[gi]    = err_any  && (win_reg == 1'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Scoreboard bench for soc_periph_arbiter.
// Stimulus pushes the expected peripheral requests and master responses into
// queues. A monitor pops and compares them when the DUT presents them.
module tb_soc_periph_arbiter;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [1:0]        m_req_i, m_we_i;
    logic [1:0][63:0]  m_addr_i, m_wdata_i;
    logic [1:0][7:0]   m_be_i;
    logic [1:0]        m_gnt_o, m_rvalid_o, m_err_o;
    logic [63:0]       m_rdata_o;
    logic              s_req_o, s_we_o;
    logic [63:0]       s_addr_o, s_wdata_o;
    logic [7:0]        s_be_o;
    logic [10:0]       s_sel_o;
    logic              s_gnt_i, s_rvalid_i, s_err_i;
    logic [63:0]       s_rdata_i;

    always #5 clk_i = ~clk_i;

    soc_periph_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
        .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_err_o(m_err_o),
        .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_be_o(s_be_o), .s_sel_o(s_sel_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_err_i(s_err_i),
        .s_rdata_i(s_rdata_i)
    );

    typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] be; } cmd_t;
    typedef struct { logic [10:0] sel; logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] be; } slv_t;
    typedef struct { int m; logic [63:0] rdata; logic err; } rsp_t;

    cmd_t cmd_q0[$];
    cmd_t cmd_q1[$];
    slv_t slv_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int unexp_rvalid = 0;
    int busy[2];
    int wcnt[2];

    // Peripheral model knobs
    int          per_gnt_dly = 0;
    int          per_rsp_dly = 0;
    logic [63:0] per_rdata = 64'h0;
    logic        per_err = 1'b0;
    logic        per_abort = 1'b0;

    // Peripheral model: grant after per_gnt_dly cycles of s_req_o.
    // Respond per_rsp_dly cycles after the grant cycle.
    initial begin : peripheral
        int pst;
        int pcnt;
        pst = 0; pcnt = 0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
            if (per_abort) begin
                pst = 0; pcnt = 0;
            end else if (pst == 0) begin
                if (s_req_o) begin
                    if (pcnt >= per_gnt_dly) begin
                        s_gnt_i = 1'b1; pst = 1; pcnt = 0;
                    end else begin
                        pcnt++;
                    end
                end else begin
                    pcnt = 0;
                end
            end else begin
                if (pcnt >= per_rsp_dly) begin
                    s_rvalid_i = 1'b1; s_rdata_i = per_rdata; s_err_i = per_err;
                    pst = 0; pcnt = 0;
                end else begin
                    pcnt++;
                end
            end
        end
    end

    // Master drivers: present one command at a time and hold it until granted.
    initial begin : masters
        cmd_t c;
        m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0;
        busy[0] = 0; busy[1] = 0; wcnt[0] = 0; wcnt[1] = 0;
        forever begin
            @(negedge clk_i);
            for (int m = 0; m < 2; m++) begin
                if (busy[m] != 0) begin
                    if (m_gnt_o[m]) begin
                        busy[m] = 0; m_req_i[m] = 1'b0;
                    end else begin
                        wcnt[m]++;
                        if (wcnt[m] > 600) begin
                            errors++;
                            $display("FAIL grant_wait m%0d: no m_gnt_o after %0d cycles, required a grant", m, wcnt[m]);
                            busy[m] = 0; m_req_i[m] = 1'b0;
                        end
                    end
                end
                if (busy[m] == 0 && ((m == 0) ? cmd_q0.size() : cmd_q1.size()) > 0) begin
                    if (m == 0) c = cmd_q0.pop_front();
                    else        c = cmd_q1.pop_front();
                    m_addr_i[m] = c.addr; m_we_i[m] = c.we;
                    m_wdata_i[m] = c.wdata; m_be_i[m] = c.be;
                    m_req_i[m] = 1'b1; busy[m] = 1; wcnt[m] = 0;
                end
            end
        end
    end

    // Monitor: compare peripheral requests and master responses against the queues.
    initial begin : monitor
        logic sreq_prev;
        slv_t e;
        rsp_t r;
        logic [1:0] exp_v;
        logic [1:0] exp_e;
        sreq_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (s_req_o && !sreq_prev) begin
                    checks++;
                    if (slv_q.size() == 0) begin
                        errors++;
                        $display("FAIL s_req_unexpected: got s_req_o=1 addr=%h, required no peripheral request", s_addr_o);
                    end else begin
                        e = slv_q.pop_front();
                        $display("slv req addr=%h sel=%h we=%b", s_addr_o, s_sel_o, s_we_o);
                        if (s_sel_o !== e.sel || s_addr_o !== e.addr || s_we_o !== e.we ||
                            s_be_o !== e.be || (e.we && s_wdata_o !== e.wdata)) begin
                            errors++;
                            $display("FAIL s_req_fields: got sel=%h addr=%h we=%b wdata=%h be=%h, required sel=%h addr=%h we=%b wdata=%h be=%h",
                                     s_sel_o, s_addr_o, s_we_o, s_wdata_o, s_be_o, e.sel, e.addr, e.we, e.wdata, e.be);
                        end
                    end
                end
                if (!s_req_o && s_sel_o !== 11'h0) begin
                    errors++;
                    $display("FAIL sel_idle: got s_sel_o=%h with s_req_o=0, required 0", s_sel_o);
                end
                if ($countones(m_gnt_o) > 1) begin
                    errors++;
                    $display("FAIL gnt_onehot: got m_gnt_o=%b, required at most one bit", m_gnt_o);
                end
                if (|m_rvalid_o) begin
                    checks++;
                    if (rsp_q.size() == 0) begin
                        errors++; unexp_rvalid++;
                        $display("FAIL rsp_unexpected: got m_rvalid_o=%b, required none", m_rvalid_o);
                    end else begin
                        r = rsp_q.pop_front();
                        exp_v = 2'(1 << r.m);
                        exp_e = r.err ? exp_v : 2'b00;
                        $display("rsp m_rvalid=%b rdata=%h err=%b", m_rvalid_o, m_rdata_o, m_err_o);
                        if (m_rvalid_o !== exp_v || m_rdata_o !== r.rdata || m_err_o !== exp_e) begin
                            errors++;
                            $display("FAIL rsp_fields: got rvalid=%b rdata=%h err=%b, required rvalid=%b rdata=%h err=%b",
                                     m_rvalid_o, m_rdata_o, m_err_o, exp_v, r.rdata, exp_e);
                        end
                    end
                end
            end
            sreq_prev = s_req_o;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Queue one master command with explicit expected response.
    task automatic issue_raw(input int m, input logic [63:0] addr, input logic we,
                             input logic [63:0] wdata, input logic [7:0] be,
                             input logic [10:0] sel, input logic [63:0] rdata_exp,
                             input logic err_exp, input bit expect_rsp);
        cmd_t c;
        slv_t s;
        rsp_t r;
        c = '{addr, we, wdata, be};
        if (m == 0) cmd_q0.push_back(c);
        else        cmd_q1.push_back(c);
        if (sel != 11'h0) begin
            s = '{sel, addr, we, wdata, be};
            slv_q.push_back(s);
        end
        if (expect_rsp) begin
            r = '{m, rdata_exp, err_exp};
            rsp_q.push_back(r);
        end
    endtask

    // Hit returns the peripheral data/error; miss returns 0 with error.
    task automatic issue(input int m, input logic [63:0] addr, input logic we,
                         input logic [63:0] wdata, input logic [7:0] be, input logic [10:0] sel);
        if (sel != 11'h0) issue_raw(m, addr, we, wdata, be, sel, per_rdata, per_err, 1'b1);
        else              issue_raw(m, addr, we, wdata, be, sel, 64'h0, 1'b1, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || slv_q.size() != 0 || cmd_q0.size() != 0 ||
                cmd_q1.size() != 0 || busy[0] != 0 || busy[1] != 0) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending responses after %0d cycles, required 0", name, rsp_q.size(), n);
            rsp_q.delete(); slv_q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_s_req"},  64'(s_req_o),    64'h0);
        chk({name, "_s_sel"},  64'(s_sel_o),    64'h0);
        chk({name, "_m_gnt"},  64'(m_gnt_o),    64'h0);
        chk({name, "_m_rvld"}, 64'(m_rvalid_o), 64'h0);
        chk({name, "_m_err"},  64'(m_err_o),    64'h0);
        chk({name, "_m_rdata"}, m_rdata_o,      64'h0);
        chk({name, "_s_addr"}, s_addr_o,        64'h0);
        chk({name, "_s_we"},   64'(s_we_o),     64'h0);
    endtask

    typedef struct { logic [63:0] addr; logic [10:0] sel; } dec_vec_t;
    dec_vec_t dec_tab[14];

    initial begin : stimulus
        int n;
        dec_tab[0]  = '{64'h0000_0000_8000_0000, 11'h002};   // DRAM base
        dec_tab[1]  = '{64'h0000_0000_BFFF_FFFF, 11'h002};   // DRAM last
        dec_tab[2]  = '{64'h0000_0000_C000_0000, 11'h000};   // DRAM end
        dec_tab[3]  = '{64'h0000_0000_0000_0000, 11'h400};   // Debug base
        dec_tab[4]  = '{64'h0000_0000_0000_0FFF, 11'h400};   // Debug last
        dec_tab[5]  = '{64'h0000_0000_0000_1000, 11'h000};   // gap after Debug
        dec_tab[6]  = '{64'h0000_0000_0FFF_FFFE, 11'h080};   // PLIC last
        dec_tab[7]  = '{64'h0000_0000_0FFF_FFFF, 11'h000};   // PLIC end
        dec_tab[8]  = '{64'h0000_0000_5000_0000, 11'h001};   // CLIC base
        dec_tab[9]  = '{64'h0000_0000_020B_FFFF, 11'h100};   // CLINT last
        dec_tab[10] = '{64'h0000_0000_0001_FFFF, 11'h200};   // ROM last
        dec_tab[11] = '{64'h0000_0000_3000_FFFF, 11'h008};   // Ethernet last
        dec_tab[12] = '{64'h0001_0000_1000_0000, 11'h000};   // upper bits set: no alias
        dec_tab[13] = '{64'hFFFF_FFFF_FFFF_FFFF, 11'h000};   // top of space

        // Reset state
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Simultaneous requests after reset, each repeated once: M0, M1, M0, M1
        per_rdata = 64'h1111_2222_3333_4444; per_err = 1'b0;
        issue(0, 64'h1000_0010, 1'b0, 64'h0, 8'hFF, 11'h040);
        issue(1, 64'h1800_0020, 1'b0, 64'h0, 8'hFF, 11'h020);
        issue(0, 64'h2000_0030, 1'b0, 64'h0, 8'hFF, 11'h010);
        issue(1, 64'h4000_0040, 1'b1, 64'h5555_AAAA_0000_FFFF, 8'h0F, 11'h004);
        drain("rr_order");

        // M0 read from UART, grant immediately, response next cycle
        per_rdata = 64'h0000_0000_DEAD_BEEF; per_err = 1'b0;
        issue(0, 64'h1000_0000, 1'b0, 64'h0, 8'hFF, 11'h040);
        drain("uart_read");

        // M1 write to an unmapped address: local grant and error response
        issue(1, 64'h6000_0000, 1'b1, 64'h0000_0000_0000_ABCD, 8'hFF, 11'h000);
        drain("decode_miss");

        // Peripheral error is forwarded; delayed handshake on both phases
        per_rdata = 64'h0BAD_0BAD_0BAD_0BAD; per_err = 1'b1;
        per_gnt_dly = 3; per_rsp_dly = 4;
        issue(1, 64'h2000_1234, 1'b0, 64'h0, 8'hFF, 11'h010);
        drain("slave_err");
        per_gnt_dly = 0; per_rsp_dly = 0; per_err = 1'b0;

        // Region boundary table
        per_rdata = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 14; i++)
            issue(0, dec_tab[i].addr, 1'b0, 64'h0, 8'hFF, dec_tab[i].sel);
        drain("decode_table");

        // Reset during WAIT_RSP, then a late s_rvalid_i must be ignored
        per_rsp_dly = 6; per_rdata = 64'hFEED_FACE_CAFE_F00D;
        issue_raw(0, 64'h1000_0100, 1'b0, 64'h0, 8'hFF, 11'h040, 64'h0, 1'b0, 1'b0);
        n = 0;
        while ((cmd_q0.size() != 0 || busy[0] != 0) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_mid_granted", 64'(n < 100), 64'h1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("late_rvalid_ignored", 64'(unexp_rvalid), 64'h0);
        chk("late_rvalid_slv_q", 64'(slv_q.size()), 64'h0);
        per_rsp_dly = 0;

        // Priority is back to master 0 after the reset
        per_rdata = 64'h0000_0000_0000_00A5;
        issue(0, 64'h4000_0000, 1'b0, 64'h0, 8'hFF, 11'h004);
        issue(1, 64'h3000_0000, 1'b0, 64'h0, 8'hFF, 11'h008);
        drain("post_reset_prio");

`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
        // Peripheral never grants: REQ times out into a decode-style error
        per_gnt_dly = 100000;
        issue_raw(0, 64'h1000_0000, 1'b0, 64'h0, 8'hFF, 11'h040, 64'h0, 1'b1, 1'b1);
        drain("timeout_req");
        per_gnt_dly = 0;

        // Peripheral never responds: WAIT_RSP times out into an error response
        per_rsp_dly = 100000;
        issue_raw(1, 64'h1800_0000, 1'b0, 64'h0, 8'hFF, 11'h020, 64'h0, 1'b1, 1'b1);
        drain("timeout_rsp");
        per_abort = 1'b1;
        repeat (2) @(negedge clk_i);
        per_abort = 1'b0;
        per_rsp_dly = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/soc_periph_arbiter.md
SOC_PERIPH_ARBITER -- requirements
Module: soc_periph_arbiter

Interface
REQ-001: Parameter NrMasters, default 2, number of requesting masters (fixed to 2 in this revision).
REQ-002: Parameter AddrWidth, default 64, request address width.
REQ-003: Parameter DataWidth, default 64, read/write data width; byte-enable width is DataWidth/8.
REQ-004: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005: rst_ni  input  1  asynchronous active-low reset.
REQ-006: m_req_i / m_we_i  input  [NrMasters]  per-master request / write flag; held stable by the master until its m_gnt_o.
REQ-007: m_addr_i / m_wdata_i / m_be_i  input  [NrMasters][AddrWidth|DataWidth|DataWidth/8]  per-master address / write data / byte enables.
REQ-008: m_gnt_o / m_rvalid_o / m_err_o  output  [NrMasters]  per-master grant / response valid / error flag.
REQ-009: m_rdata_o  output  DataWidth  response data, shared by all masters, qualified by m_rvalid_o.
REQ-010: s_req_o / s_we_o  output  1  request / write flag to the shared peripheral port.
REQ-011: s_addr_o / s_wdata_o / s_be_o  output  AddrWidth / DataWidth / DataWidth/8  latched request fields.
REQ-012: s_sel_o  output  11  one-hot target select, bit index equals ariane_soc::axi_slaves_t (CLIC=0 ... Debug=10).
REQ-013: s_gnt_i / s_rvalid_i / s_err_i  input  1  peripheral grant / response valid / error.
REQ-014: s_rdata_i  input  DataWidth  peripheral read data.

Function
REQ-015: FSM states: IDLE, REQ, WAIT_RSP, DEC_GNT, DEC_RSP; one outstanding transaction at a time.
REQ-016: IDLE: if any m_req_i is high, pick the winner by round-robin, latch its index, addr, we, wdata and be, and the decoded select; next state REQ on decode hit, DEC_GNT on miss.
REQ-017: Round-robin: the master not served last has priority; after reset, master 0 has priority; a lone requester always wins.
REQ-018: Decode: hit when Base <= addr < Base+Length for one ariane_soc region: Debug 0x0/0x1000, ROM 0x10000/0x10000, CLINT 0x2000000/0xC0000, PLIC 0xC000000/0x3FFFFFF, UART 0x10000000/0x1000, Timer 0x18000000/0x1000, SPI 0x20000000/0x800000, Ethernet 0x30000000/0x10000, GPIO 0x40000000/0x1000, CLIC 0x50000000/0x3FFFFFF, DRAM 0x80000000/0x40000000.
REQ-019: Decode arithmetic is 64-bit unsigned with no wrap; the end address is exclusive.
REQ-020: REQ: s_req_o=1 with latched fields and s_sel_o; on s_gnt_i, m_gnt_o[winner]=1 in the same cycle, then go to WAIT_RSP.
REQ-021: WAIT_RSP: s_req_o=0; on s_rvalid_i, m_rvalid_o[winner]=1 with m_rdata_o=s_rdata_i and m_err_o[winner]=s_err_i in the same cycle; update the round-robin pointer; go to IDLE.
REQ-022: s_rvalid_i in any state other than WAIT_RSP is ignored.
REQ-023: DEC_GNT: m_gnt_o[winner]=1 for one cycle and s_req_o stays 0; next state DEC_RSP.
REQ-024: DEC_RSP: m_rvalid_o[winner]=1, m_err_o[winner]=1, m_rdata_o=0 for one cycle; update the pointer; go to IDLE.
REQ-025: Minimum latency from IDLE request to response is 3 cycles (IDLE, REQ with s_gnt_i, WAIT_RSP with s_rvalid_i); a new arbitration can start in the cycle after a response.
REQ-026: s_sel_o is 0 whenever s_req_o=0; all m_* outputs of a non-winner are 0.

Reset
REQ-027: While rst_ni=0: state=IDLE; pointer gives master 0 priority; latched fields=0; all outputs=0.
REQ-028: Reset asserted mid-transaction aborts it with no response to the master; the master must re-issue the request.

Configuration
REQ-029: Macro SOC_PERIPH_ARB_TIMEOUT_EN enables an 8-bit timeout counter that clears on entry to REQ and increments each cycle in REQ and WAIT_RSP.
REQ-030: With SOC_PERIPH_ARB_TIMEOUT_EN, when the counter reaches 255 in REQ: drop s_req_o and go to DEC_GNT (master gets grant then error response).
REQ-031: With SOC_PERIPH_ARB_TIMEOUT_EN, when the counter reaches 255 in WAIT_RSP: go to DEC_RSP.
REQ-032: Without SOC_PERIPH_ARB_TIMEOUT_EN, there is no counter and REQ/WAIT_RSP wait indefinitely.

Verification
REQ-033: M0 reads 0x1000_0000, s_gnt_i after 0 cycles, s_rvalid_i with 0xDEAD_BEEF after 1 cycle -> s_sel_o=bit 6, m_rvalid_o[0]=1, m_rdata_o=0xDEAD_BEEF, m_err_o=0.
REQ-034: M0 and M1 request simultaneously after reset, each repeats once -> service order M0, M1, M0, M1.
REQ-035: M1 writes 0x6000_0000 -> s_req_o never rises; m_gnt_o[1] then m_rvalid_o[1] with m_err_o[1]=1, m_rdata_o=0.
REQ-036: Boundary addresses 0x8000_0000 (hit, bit 1), 0xBFFF_FFFF (hit, bit 1), 0xC000_0000 (miss) -> selects and errors as stated.
REQ-037: rst_ni pulsed low during WAIT_RSP, then late s_rvalid_i -> outputs 0, state IDLE, no m_rvalid_o generated.
REQ-038: With SOC_PERIPH_ARB_TIMEOUT_EN, s_gnt_i held 0 -> after 255 cycles in REQ, m_gnt_o then m_err_o=1 for the winner.
